// File: rtl/execute_stage.sv
// ID/EX pipeline register plus EX datapath (forwarding muxes, ALU, branch target, redirect).
// D->E latency is one cycle; no backpressure, FlushE turns the captured slot into a bubble.
module execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             FlushE,
   input  logic             RegWriteD,
   input  logic [1:0]       ResultSrcD,
   input  logic             MemWriteD,
   input  logic             StSrcD,
   input  logic             LdSrcD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic [2:0]       ALUControlD,
   input  logic             ALUSrcD,
   input  logic [WIDTH-1:0] RD1D,
   input  logic [WIDTH-1:0] RD2D,
   input  logic [WIDTH-1:0] PCD,
   input  logic [4:0]       RdD,
   input  logic [WIDTH-1:0] ImmExtD,
   input  logic [WIDTH-1:0] PCPlus4D,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] ResultW,
   output logic             RegWriteE,
   output logic [1:0]       ResultSrcE,
   output logic             MemWriteE,
   output logic             StSrcE,
   output logic             LdSrcE,
   output logic [WIDTH-1:0] ALUResultE,
   output logic [WIDTH-1:0] WriteDataE,
   output logic [4:0]       RdE,
   output logic [WIDTH-1:0] PCPlus4E,
   output logic [WIDTH-1:0] PCTargetE,
   output logic             PCSrcE
);

   logic             jump_e;
   logic             branch_e;
   logic [2:0]       alu_ctrl_e;
   logic             alu_src_e;
   logic [WIDTH-1:0] rd1_e;
   logic [WIDTH-1:0] rd2_e;
   logic [WIDTH-1:0] pc_e;
   logic [WIDTH-1:0] imm_e;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             zero;

   // A flush loads an all-zero bubble: no write, no store, no redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || FlushE) begin
         RegWriteE  <= 1'b0;
         ResultSrcE <= 2'b00;
         MemWriteE  <= 1'b0;
         StSrcE     <= 1'b0;
         LdSrcE     <= 1'b0;
         jump_e     <= 1'b0;
         branch_e   <= 1'b0;
         alu_ctrl_e <= 3'b000;
         alu_src_e  <= 1'b0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         pc_e       <= '0;
         RdE        <= 5'd0;
         imm_e      <= '0;
         PCPlus4E   <= '0;
      end else begin
         RegWriteE  <= RegWriteD;
         ResultSrcE <= ResultSrcD;
         MemWriteE  <= MemWriteD;
         StSrcE     <= StSrcD;
         LdSrcE     <= LdSrcD;
         jump_e     <= JumpD;
         branch_e   <= BranchD;
         alu_ctrl_e <= ALUControlD;
         alu_src_e  <= ALUSrcD;
         rd1_e      <= RD1D;
         rd2_e      <= RD2D;
         pc_e       <= PCD;
         RdE        <= RdD;
         imm_e      <= ImmExtD;
         PCPlus4E   <= PCPlus4D;
      end
   end

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = rd1_e;
      endcase
      case (ForwardBE)
         2'b01:   WriteDataE = ResultW;
         2'b10:   WriteDataE = ALUResultM;
         default: WriteDataE = rd2_e;
      endcase
   end

   assign src_b = alu_src_e ? imm_e : WriteDataE;

   always_comb begin
      case (alu_ctrl_e)
         3'b000:  ALUResultE = src_a + src_b;
         3'b001:  ALUResultE = src_a - src_b;
         3'b010:  ALUResultE = src_a & src_b;
         3'b011:  ALUResultE = src_a | src_b;
         3'b100:  ALUResultE = src_a ^ src_b;
         3'b101:  ALUResultE = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         3'b110:  ALUResultE = src_a << src_b[4:0];
         default: ALUResultE = src_a >> src_b[4:0];
      endcase
   end

   assign zero      = (ALUResultE == '0);
   assign PCTargetE = pc_e + imm_e;
   assign PCSrcE    = jump_e | (branch_e & zero);

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, reset/flush sequences, randomized run vs model.
module tb_execute_stage;

   typedef struct packed {
      logic        regwrite;
      logic [1:0]  resultsrc;
      logic        memwrite;
      logic        stsrc;
      logic        ldsrc;
      logic        jump;
      logic        branch;
      logic [2:0]  op;
      logic        alusrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pcp4;
   } stim_t;

   typedef struct packed {
      stim_t       d;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] alum;
      logic [31:0] resw;
      logic [31:0] e_alu;
      logic [31:0] e_wd;
      logic [31:0] e_tgt;
      logic        e_pcsrc;
   } vec_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] tgt;
      logic        pcsrc;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        FlushE;
   logic        RegWriteD, MemWriteD, StSrcD, LdSrcD, JumpD, BranchD, ALUSrcD;
   logic [1:0]  ResultSrcD;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
   logic [4:0]  RdD;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultM, ResultW;
   logic        RegWriteE, MemWriteE, StSrcE, LdSrcE, PCSrcE;
   logic [1:0]  ResultSrcE;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
   logic [4:0]  RdE;

   int checks = 0;
   int errors = 0;

   execute_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
      .StSrcD(StSrcD), .LdSrcD(LdSrcD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RD1D(RD1D), .RD2D(RD2D),
      .PCD(PCD), .RdD(RdD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .StSrcE(StSrcE), .LdSrcE(LdSrcE), .ALUResultE(ALUResultE),
      .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
      .PCTargetE(PCTargetE), .PCSrcE(PCSrcE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Reference: forwarding, ALU and redirect computed straight from the operation rules.
   function automatic res_t model(input stim_t c, input logic [1:0] fa, input logic [1:0] fb,
                                  input logic [31:0] am, input logic [31:0] rw);
      logic [31:0] a, b;
      res_t r;
      a    = (fa == 2'b01) ? rw : (fa == 2'b10) ? am : c.rd1;
      r.wd = (fb == 2'b01) ? rw : (fb == 2'b10) ? am : c.rd2;
      b    = c.alusrc ? c.imm : r.wd;
      case (c.op)
         3'd0: r.alu = a + b;
         3'd1: r.alu = a - b;
         3'd2: r.alu = a & b;
         3'd3: r.alu = a | b;
         3'd4: r.alu = a ^ b;
         3'd5: r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: r.alu = a << b[4:0];
         default: r.alu = a >> b[4:0];
      endcase
      r.tgt   = c.pc + c.imm;
      r.pcsrc = c.jump | (c.branch & (r.alu == 32'd0));
      return r;
   endfunction

   function automatic vec_t mkv(input logic [2:0] op, input logic alusrc, input logic br,
                                input logic j, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] am, input logic [31:0] rw,
                                input logic [31:0] ealu, input logic [31:0] ewd,
                                input logic [31:0] etgt, input logic epc);
      vec_t v;
      v = '0;
      v.d.op = op; v.d.alusrc = alusrc; v.d.branch = br; v.d.jump = j;
      v.d.rd1 = rd1; v.d.rd2 = rd2; v.d.imm = imm; v.d.pc = pc;
      v.fa = fa; v.fb = fb; v.alum = am; v.resw = rw;
      v.e_alu = ealu; v.e_wd = ewd; v.e_tgt = etgt; v.e_pcsrc = epc;
      return v;
   endfunction

   task automatic drive(input stim_t s, input logic fl);
      RegWriteD = s.regwrite; ResultSrcD = s.resultsrc; MemWriteD = s.memwrite;
      StSrcD = s.stsrc; LdSrcD = s.ldsrc; JumpD = s.jump; BranchD = s.branch;
      ALUControlD = s.op; ALUSrcD = s.alusrc; RD1D = s.rd1; RD2D = s.rd2;
      PCD = s.pc; RdD = s.rd; ImmExtD = s.imm; PCPlus4D = s.pcp4;
      FlushE = fl;
   endtask

   // Drive D side between edges, clock it in, return just after the capturing edge.
   task automatic apply(input stim_t s, input logic fl);
      @(negedge clk);
      drive(s, fl);
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] am, input logic [31:0] rw);
      ForwardAE = fa; ForwardBE = fb; ALUResultM = am; ResultW = rw;
      #1;
   endtask

   task automatic check_ctrl(input string tag, input stim_t c);
      chk({tag, ".RegWriteE"},  32'(RegWriteE),  32'(c.regwrite));
      chk({tag, ".ResultSrcE"}, 32'(ResultSrcE), 32'(c.resultsrc));
      chk({tag, ".MemWriteE"},  32'(MemWriteE),  32'(c.memwrite));
      chk({tag, ".StSrcE"},     32'(StSrcE),     32'(c.stsrc));
      chk({tag, ".LdSrcE"},     32'(LdSrcE),     32'(c.ldsrc));
      chk({tag, ".RdE"},        32'(RdE),        32'(c.rd));
      chk({tag, ".PCPlus4E"},   PCPlus4E,        c.pcp4);
   endtask

   task automatic check_model(input string tag, input stim_t c);
      res_t r;
      r = model(c, ForwardAE, ForwardBE, ALUResultM, ResultW);
      check_ctrl(tag, c);
      chk({tag, ".ALUResultE"}, ALUResultE, r.alu);
      chk({tag, ".WriteDataE"}, WriteDataE, r.wd);
      chk({tag, ".PCTargetE"},  PCTargetE,  r.tgt);
      chk({tag, ".PCSrcE"},     32'(PCSrcE), 32'(r.pcsrc));
   endtask

   vec_t  tbl[15];
   stim_t s, cap, z;

   initial begin
      tbl[0]  = mkv(3'd0, 0, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd12, 32'd7, 32'd0, 0);
      tbl[1]  = mkv(3'd1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd2, 2'd1, 32'h10, 32'd3,
                    32'h0D, 32'd3, 32'd0, 0);
      tbl[2]  = mkv(3'd1, 0, 1, 0, 32'd9, 32'd9, 32'hFFFFFFF8, 32'h100, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd0, 32'd9, 32'hF8, 1);
      tbl[3]  = mkv(3'd1, 0, 1, 0, 32'd9, 32'd8, 32'hFFFFFFF8, 32'h100, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd1, 32'd8, 32'hF8, 0);
      tbl[4]  = mkv(3'd2, 1, 0, 0, 32'hF0F0, 32'h55, 32'h0FF0, 32'h10, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'hF0, 32'h55, 32'h1000, 0);
      tbl[5]  = mkv(3'd3, 0, 0, 0, 32'hA0, 32'h0B, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'hAB, 32'h0B, 32'd0, 0);
      tbl[6]  = mkv(3'd4, 0, 0, 0, 32'hFF, 32'h0F, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'hF0, 32'h0F, 32'd0, 0);
      tbl[7]  = mkv(3'd5, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd1, 32'd1, 32'd0, 0);
      tbl[8]  = mkv(3'd5, 0, 0, 0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd0, 32'hFFFFFFFF, 32'd0, 0);
      tbl[9]  = mkv(3'd6, 0, 0, 0, 32'd1, 32'h24, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'h10, 32'h24, 32'd0, 0);
      tbl[10] = mkv(3'd7, 1, 0, 0, 32'h80000000, 32'd0, 32'h1F, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd1, 32'd0, 32'h1F, 0);
      tbl[11] = mkv(3'd0, 0, 0, 1, 32'd1, 32'd1, 32'h10, 32'h200, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd2, 32'd1, 32'h210, 1);
      tbl[12] = mkv(3'd0, 0, 0, 0, 32'd3, 32'd4, 32'd0, 32'd0, 2'd3, 2'd3, 32'd100, 32'd200,
                    32'd7, 32'd4, 32'd0, 0);
      tbl[13] = mkv(3'd0, 0, 0, 0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                    32'd1, 32'd2, 32'd0, 0);
      tbl[14] = mkv(3'd1, 0, 1, 0, 32'd5, 32'd6, 32'd8, 32'h40, 2'd0, 2'd2, 32'd5, 32'd0,
                    32'd0, 32'd5, 32'h48, 1);

      z = '0;
      rst_n = 1'b0;
      drive(z, 1'b0);
      set_fwd(2'd0, 2'd0, 32'd0, 32'd0);
      check_model("reset", z);
      #10;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         tbl[i].d.rd        = 5'(i + 1);
         tbl[i].d.pcp4      = tbl[i].d.pc + 32'd4;
         tbl[i].d.regwrite  = 1'(i);
         tbl[i].d.resultsrc = 2'(i);
         tbl[i].d.memwrite  = 1'(i >> 1);
         tbl[i].d.stsrc     = 1'(i >> 2);
         tbl[i].d.ldsrc     = 1'(i >> 3);
         apply(tbl[i].d, 1'b0);
         set_fwd(tbl[i].fa, tbl[i].fb, tbl[i].alum, tbl[i].resw);
         check_ctrl($sformatf("vec%0d", i), tbl[i].d);
         chk($sformatf("vec%0d.ALUResultE", i), ALUResultE, tbl[i].e_alu);
         chk($sformatf("vec%0d.WriteDataE", i), WriteDataE, tbl[i].e_wd);
         chk($sformatf("vec%0d.PCTargetE", i),  PCTargetE,  tbl[i].e_tgt);
         chk($sformatf("vec%0d.PCSrcE", i),     32'(PCSrcE), 32'(tbl[i].e_pcsrc));
      end

      // Flush at the edge discards a store/write/jump.
      s = tbl[11].d;
      s.memwrite = 1'b1; s.regwrite = 1'b1; s.rd = 5'd7;
      apply(s, 1'b1);
      set_fwd(2'd0, 2'd0, 32'd0, 32'd0);
      check_model("flush", z);

      // Async reset between edges clears a live write/jump before the next edge.
      apply(s, 1'b0);
      chk("pre_rst.RegWriteE", 32'(RegWriteE), 32'd1);
      chk("pre_rst.PCSrcE", 32'(PCSrcE), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_model("async_rst", z);
      #1;
      rst_n = 1'b1;
      apply(tbl[7].d, 1'b0);
      chk("slt_after_rst.ALUResultE", ALUResultE, 32'd1);

      // Reset released with flush pending: flush wins at the first edge.
      @(negedge clk);
      rst_n = 1'b0;
      drive(s, 1'b1);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_model("rst_flush", z);

      for (int k = 0; k < 300; k++) begin
         logic fl;
         s = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(2) == 0) s.rd2 = s.rd1;
         if ($urandom_range(3) == 0) s.alusrc = 1'b0;
         fl = ($urandom_range(7) == 0);
         apply(s, fl);
         cap = fl ? z : s;
         set_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
         check_model($sformatf("rnd%0d", k), cap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
